// File: rtl/prbs_gen_chk.sv
// Maximal-length LFSR generator with a self-synchronising sequence checker.
// The checker locks on a clean stream, then counts errors and drops lock on a burst of misses.
module prbs_gen_chk #(
   parameter int               WIDTH    = 7,
   parameter logic [WIDTH-1:0] TAPS     = 7'h41,
   parameter logic [WIDTH-1:0] SEED     = '1,
   parameter int               LOCK_CNT = 2*WIDTH,
   parameter int               LOSS_CNT = 4,
   parameter int               ERR_W    = 16
) (
   input  logic             clk,
   input  logic             res,
   input  logic             gen_en,
   input  logic             load,
   input  logic [WIDTH-1:0] seed,
   output logic             y,
   output logic [WIDTH-1:0] gen_state,
   input  logic             chk_en,
   input  logic             din,
   input  logic             err_clr,
   output logic             lock,
   output logic             err,
   output logic [ERR_W-1:0] err_cnt
);

   localparam logic [WIDTH-1:0] ONES     = '1;
   localparam logic [WIDTH-1:0] RST_SEED = (SEED == '0) ? ONES : SEED;
   localparam int               FW       = $clog2(WIDTH + 1);
   localparam int               MW       = $clog2(LOCK_CNT + 1);
   localparam int               LW       = $clog2(LOSS_CNT + 1);
   localparam logic [FW-1:0]    FILL_FULL = FW'(WIDTH);
   localparam logic [MW-1:0]    MATCH_LIM = MW'(LOCK_CNT);
   localparam logic [LW-1:0]    MISS_LIM  = LW'(LOSS_CNT);

   typedef enum logic {SEARCH, LOCKED} state_t;

   function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   logic [WIDTH-1:0] gen_q, gen_d;
   logic             gen_fb;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] c_q, c_d;
   logic [FW-1:0]    fill_q, fill_d;
   logic [MW-1:0]    match_q, match_d;
   logic [LW-1:0]    miss_q, miss_d;
   logic             err_q, err_d;
   logic [ERR_W-1:0] cnt_q, cnt_d;
   logic             exp_bit;

   assign gen_fb  = ^(gen_q & TAPS);
   assign exp_bit = ^(c_q & TAPS);

   always_comb begin
      gen_d = gen_q;
      if (load) begin
         gen_d = (seed == '0) ? ONES : seed;
      end else if (gen_en) begin
         gen_d = {gen_fb, gen_q[WIDTH-1:1]};
      end
   end

   always_comb begin
      state_d = state_q;
      c_d     = c_q;
      fill_d  = fill_q;
      match_d = match_q;
      miss_d  = miss_q;
      err_d   = 1'b0;
      cnt_d   = cnt_q;
      if (chk_en) begin
         case (state_q)
            SEARCH: begin
               c_d = {din, c_q[WIDTH-1:1]};
               if (fill_q != FILL_FULL) fill_d = fill_q + 1'b1;
               // An all-zero register predicts zeros forever, so it must never count as a match.
               if ((fill_q == FILL_FULL) && (c_q != '0) && (din == exp_bit)) begin
                  match_d = match_q + 1'b1;
               end else begin
                  match_d = '0;
               end
               if (match_d == MATCH_LIM) begin
                  state_d = LOCKED;
                  miss_d  = '0;
               end
            end
            LOCKED: begin
               // Free-run on our own prediction so line errors do not corrupt the reference.
               c_d = {exp_bit, c_q[WIDTH-1:1]};
               if (din != exp_bit) begin
                  err_d  = 1'b1;
                  cnt_d  = sat_inc(cnt_q);
                  miss_d = miss_q + 1'b1;
               end else begin
                  miss_d = '0;
               end
               if (miss_d == MISS_LIM) begin
                  state_d = SEARCH;
                  fill_d  = '0;
                  match_d = '0;
                  c_d     = '0;
               end
            end
            default: ;
         endcase
      end
      if (err_clr) cnt_d = ERR_W'(err_d);
   end

   always_ff @(posedge clk or posedge res) begin
      if (res) begin
         gen_q   <= RST_SEED;
         state_q <= SEARCH;
         c_q     <= '0;
         fill_q  <= '0;
         match_q <= '0;
         miss_q  <= '0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         gen_q   <= gen_d;
         state_q <= state_d;
         c_q     <= c_d;
         fill_q  <= fill_d;
         match_q <= match_d;
         miss_q  <= miss_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end

   assign y         = gen_q[0];
   assign gen_state = gen_q;
   assign lock      = (state_q == LOCKED);
   assign err       = err_q;
   assign err_cnt   = cnt_q;

endmodule

// File: tb/tb_prbs_gen_chk.sv
// Directed bench: 4-bit instance exercises the generator, default 7-bit instance the checker.
module tb_prbs_gen_chk;

   logic clk = 1'b0;
   logic res = 1'b1;
   always #5 clk = ~clk;

   // 4-bit generator instance
   logic        gen_en4 = 0, load4 = 0, chk_en4 = 0, din4 = 0, err_clr4 = 0;
   logic [3:0]  seed4 = 0, gen_state4;
   logic        y4, lock4, err4;
   logic [15:0] err_cnt4;

   // default 7-bit instance
   logic        gen_en7 = 0, load7 = 0, chk_en7 = 0, err_clr7 = 0;
   logic        loop7 = 0, inv7 = 0, din_drv7 = 0;
   logic [6:0]  seed7 = 0, gen_state7;
   logic        y7, lock7, err7, din7;
   logic [15:0] err_cnt7;

   assign din7 = loop7 ? (y7 ^ inv7) : din_drv7;

   prbs_gen_chk #(.WIDTH(4), .TAPS(4'b1001), .SEED(4'hF)) u4 (
      .clk(clk), .res(res), .gen_en(gen_en4), .load(load4), .seed(seed4),
      .y(y4), .gen_state(gen_state4), .chk_en(chk_en4), .din(din4),
      .err_clr(err_clr4), .lock(lock4), .err(err4), .err_cnt(err_cnt4));

   prbs_gen_chk u7 (
      .clk(clk), .res(res), .gen_en(gen_en7), .load(load7), .seed(seed7),
      .y(y7), .gen_state(gen_state7), .chk_en(chk_en7), .din(din7),
      .err_clr(err_clr7), .lock(lock7), .err(err7), .err_cnt(err_cnt7));

   int total = 0;
   int bad   = 0;
   logic [6:0] gm = 7'h7F;

   task automatic tick;
      @(posedge clk);
      if (gen_en7 && !load7) gm = {^(gm & 7'h41), gm[6:1]};
      #1;
   endtask

   task automatic test_reset;
      tick; tick;
      total++; if (gen_state4 !== 4'hF) begin bad++; $display("FAIL rst_gen4: got %h want f", gen_state4); end
      total++; if (y4 !== 1'b1) begin bad++; $display("FAIL rst_y4: got %b want 1", y4); end
      total++; if (gen_state7 !== 7'h7F) begin bad++; $display("FAIL rst_gen7: got %h want 7f", gen_state7); end
      total++; if (lock7 !== 1'b0) begin bad++; $display("FAIL rst_lock: got %b want 0", lock7); end
      total++; if (err7 !== 1'b0) begin bad++; $display("FAIL rst_err: got %b want 0", err7); end
      total++; if (err_cnt7 !== 16'd0) begin bad++; $display("FAIL rst_cnt: got %0d want 0", err_cnt7); end
      res = 1'b0;
   endtask

   task automatic test_gen_sequence;
      bit seq [15] = '{1,1,1,1,0,1,0,1,1,0,0,1,0,0,0};
      total++; if (y4 !== seq[0]) begin bad++; $display("FAIL seq_y0: got %b want %b", y4, seq[0]); end
      gen_en4 = 1'b1;
      for (int k = 1; k <= 30; k++) begin
         tick;
         total++; if (y4 !== seq[k % 15]) begin bad++; $display("FAIL seq_y%0d: got %b want %b", k, y4, seq[k % 15]); end
         if (k % 15 == 0) begin
            total++; if (gen_state4 !== 4'hF) begin bad++; $display("FAIL seq_period%0d: got %h want f", k, gen_state4); end
         end
      end
      gen_en4 = 1'b0;
   endtask

   task automatic test_load_enable;
      gen_en4 = 1'b1; tick;
      total++; if (gen_state4 !== 4'h7) begin bad++; $display("FAIL step_f: got %h want 7", gen_state4); end
      gen_en4 = 1'b0; load4 = 1'b1; seed4 = 4'h0; tick;
      total++; if (gen_state4 !== 4'hF) begin bad++; $display("FAIL load_zero: got %h want f", gen_state4); end
      gen_en4 = 1'b1; seed4 = 4'h6; tick;
      total++; if (gen_state4 !== 4'h6) begin bad++; $display("FAIL load_prio: got %h want 6", gen_state4); end
      load4 = 1'b0; tick;
      total++; if (gen_state4 !== 4'h3) begin bad++; $display("FAIL step_6: got %h want 3", gen_state4); end
      gen_en4 = 1'b0;
      for (int k = 0; k < 5; k++) begin
         tick;
         total++; if (gen_state4 !== 4'h3) begin bad++; $display("FAIL hold%0d: got %h want 3", k, gen_state4); end
      end
   endtask

   task automatic test_lock;
      int early = 0;
      int pulses = 0;
      loop7 = 1'b1; gen_en7 = 1'b1; chk_en7 = 1'b1;
      for (int i = 1; i <= 21; i++) begin
         tick;
         if (i < 20 && lock7 !== 1'b0) early++;
         if (i == 20) begin
            total++; if (lock7 !== 1'b0) begin bad++; $display("FAIL lock_early: got %b want 0 at bit 20", lock7); end
         end
         if (i == 21) begin
            total++; if (lock7 !== 1'b1) begin bad++; $display("FAIL lock_rise: got %b want 1 at bit 21", lock7); end
         end
      end
      total++; if (early !== 0) begin bad++; $display("FAIL lock_pre: early lock cycles %0d want 0", early); end
      for (int i = 0; i < 1000; i++) begin
         tick;
         if (err7 !== 1'b0) pulses++;
      end
      total++; if (pulses !== 0) begin bad++; $display("FAIL clean_err: pulses %0d want 0", pulses); end
      total++; if (err_cnt7 !== 16'd0) begin bad++; $display("FAIL clean_cnt: got %0d want 0", err_cnt7); end
      total++; if (lock7 !== 1'b1) begin bad++; $display("FAIL clean_lock: got %b want 1", lock7); end
      total++; if (gen_state7 !== gm) begin bad++; $display("FAIL gen7_model: got %h want %h", gen_state7, gm); end
   endtask

   task automatic test_error_inject;
      for (int n = 1; n <= 3; n++) begin
         inv7 = 1'b1; tick; inv7 = 1'b0;
         total++; if (err7 !== 1'b1) begin bad++; $display("FAIL inj%0d_pulse: got %b want 1", n, err7); end
         tick;
         total++; if (err7 !== 1'b0) begin bad++; $display("FAIL inj%0d_end: got %b want 0", n, err7); end
         for (int k = 0; k < 8; k++) tick;
      end
      total++; if (err_cnt7 !== 16'd3) begin bad++; $display("FAIL inj_cnt: got %0d want 3", err_cnt7); end
      total++; if (lock7 !== 1'b1) begin bad++; $display("FAIL inj_lock: got %b want 1", lock7); end
      inv7 = 1'b1; err_clr7 = 1'b1; tick; inv7 = 1'b0; err_clr7 = 1'b0;
      total++; if (err_cnt7 !== 16'd1) begin bad++; $display("FAIL clr_err: got %0d want 1", err_cnt7); end
      for (int k = 0; k < 8; k++) tick;
   endtask

   task automatic test_loss_of_lock;
      int waited = 0;
      int relock = 0;
      int lk = 0;
      err_clr7 = 1'b1; tick; err_clr7 = 1'b0;
      total++; if (err_cnt7 !== 16'd0) begin bad++; $display("FAIL loss_clr: got %0d want 0", err_cnt7); end
      // start the zero burst where the next four predicted bits are ones
      while (gm[3:0] !== 4'hF && waited < 300) begin tick; waited++; end
      total++; if (gm[3:0] !== 4'hF) begin bad++; $display("FAIL loss_wait: timed out after %0d cycles", waited); end
      loop7 = 1'b0; din_drv7 = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         tick;
         if (i == 3) begin
            total++; if (lock7 !== 1'b1) begin bad++; $display("FAIL loss_hold: got %b want 1 after 3 misses", lock7); end
         end
      end
      total++; if (lock7 !== 1'b0) begin bad++; $display("FAIL loss_drop: got %b want 0", lock7); end
      total++; if (err_cnt7 !== 16'd4) begin bad++; $display("FAIL loss_cnt: got %0d want 4", err_cnt7); end
      total++; if (err7 !== 1'b1) begin bad++; $display("FAIL loss_err: got %b want 1", err7); end
      for (int i = 0; i < 100; i++) begin
         tick;
         if (lock7 !== 1'b0) lk++;
      end
      total++; if (lk !== 0) begin bad++; $display("FAIL zero_lock: locked cycles %0d want 0", lk); end
      total++; if (err_cnt7 !== 16'd4) begin bad++; $display("FAIL zero_cnt: got %0d want 4", err_cnt7); end
      loop7 = 1'b1;
      while (lock7 !== 1'b1 && relock < 60) begin tick; relock++; end
      total++; if (lock7 !== 1'b1) begin bad++; $display("FAIL relock: got %b want 1 within 60 bits", lock7); end
      for (int k = 0; k < 10; k++) tick;
   endtask

   task automatic test_reset_mid;
      err_clr7 = 1'b1; tick; err_clr7 = 1'b0;
      for (int n = 1; n <= 5; n++) begin
         inv7 = 1'b1; tick; inv7 = 1'b0;
         if (n < 5) for (int k = 0; k < 5; k++) tick;
      end
      total++; if (err_cnt7 !== 16'd5) begin bad++; $display("FAIL pre_rst_cnt: got %0d want 5", err_cnt7); end
      total++; if (err7 !== 1'b1) begin bad++; $display("FAIL pre_rst_err: got %b want 1", err7); end
      total++; if (lock7 !== 1'b1) begin bad++; $display("FAIL pre_rst_lock: got %b want 1", lock7); end
      #2 res = 1'b1;
      #1;
      total++; if (lock7 !== 1'b0) begin bad++; $display("FAIL arst_lock: got %b want 0", lock7); end
      total++; if (err_cnt7 !== 16'd0) begin bad++; $display("FAIL arst_cnt: got %0d want 0", err_cnt7); end
      total++; if (err7 !== 1'b0) begin bad++; $display("FAIL arst_err: got %b want 0", err7); end
      total++; if (gen_state7 !== 7'h7F) begin bad++; $display("FAIL arst_gen: got %h want 7f", gen_state7); end
      gen_en7 = 1'b0; chk_en7 = 1'b0; loop7 = 1'b0;
      #2 res = 1'b0;
   endtask

   initial begin
      test_reset;
      test_gen_sequence;
      test_load_enable;
      test_lock;
      test_error_inject;
      test_loss_of_lock;
      test_reset_mid;
      tick;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/prbs_gen_chk.md
Name: prbs_gen_chk

Overview:
Parametrised maximal-length LFSR (m-sequence) generator paired with a self-synchronising sequence checker.
- Generator emits one PRBS bit per enabled clock. Its polynomial, width and seed are set by parameter, and the seed can be reloaded at run time.
- Checker takes a serial bit stream, locks onto the same polynomial, then counts bit errors and detects loss of lock.
- Used as a link/loopback test source and sink in the same design.

Parameters:
- WIDTH, 7, LFSR length in bits (3..32).
- TAPS, 7'h41, feedback mask. Bit i set means state bit i is XORed into the feedback. Default gives x^7+x^6+1 order equivalent. WIDTH=4 with TAPS=4'b1001 is the 4-bit m-sequence.
- SEED, all ones, generator state after reset. A zero seed is replaced by all ones.
- LOCK_CNT, 2*WIDTH, consecutive correct predictions needed to declare lock (must be >= WIDTH).
- LOSS_CNT, 4, consecutive mismatches while locked that drop lock.
- ERR_W, 16, error counter width.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- res  in  1  asynchronous reset, active-high.
- gen_en  in  1  advance the generator one step.
- load  in  1  synchronous seed load; has priority over gen_en.
- seed  in  WIDTH  value loaded when load=1.
- y  out  1  generator output bit, equal to gen_state[0].
- gen_state  out  WIDTH  current generator register.
- chk_en  in  1  din is valid this cycle.
- din  in  1  received serial bit.
- err_clr  in  1  synchronous clear of err_cnt.
- lock  out  1  checker locked.
- err  out  1  one-cycle pulse: a locked-mode mismatch occurred.
- err_cnt  out  ERR_W  saturating count of locked-mode mismatches.

Behaviour:
- Reset values (res=1, asynchronous):
  - gen_state=SEED, or all ones if SEED==0; y=gen_state[0].
  - chk register=0, fill=0, match/miss counters=0.
  - FSM=SEARCH, lock=0, err=0, err_cnt=0.
- Generator:
  - fb = XOR-reduce(gen_state & TAPS).
  - When gen_en=1: gen_state <= {fb, gen_state[WIDTH-1:1]} (shift right, feedback into MSB).
  - When gen_en=0: gen_state holds.
  - When load=1: gen_state <= seed, or all ones if seed==0, regardless of gen_en.
  - y changes on the clock after the step; no extra latency.
- Checker register c (WIDTH bits): exp = XOR-reduce(c & TAPS) is the predicted next bit. Nothing changes when chk_en=0.
- FSM state SEARCH, on each chk_en cycle:
  - c <= {din, c[WIDTH-1:1]}; fill increments, saturating at WIDTH.
  - Match = (fill==WIDTH) and (c!=0) and (din==exp); match counter increments. Otherwise match counter goes to 0.
  - A zero c never counts as a match, so an all-zero line cannot lock.
  - When the match counter reaches LOCK_CNT: go to LOCKED and set lock=1 on that same edge. Miss counter goes to 0.
- FSM state LOCKED, on each chk_en cycle:
  - c <= {exp, c[WIDTH-1:1]}. The checker free-runs, so errors do not propagate into the prediction.
  - If din!=exp: err=1 for the next cycle, err_cnt increments (saturating at all ones), miss counter increments.
  - If din==exp: miss counter goes to 0.
  - When the miss counter reaches LOSS_CNT: go to SEARCH. lock=0, fill=0, match counter=0, c=0 on that edge. The LOSS_CNT-th mismatch still counts in err_cnt.
- err is registered and is 0 in every cycle not described above, including cycles where chk_en=0.
- err_clr:
  - err_cnt <= 0 when err_clr=1.
  - If err_clr and an error occur in the same cycle, err_cnt <= 1.
  - err_clr does not affect lock or the FSM.
- Generator and checker are independent. Both may be enabled in the same cycle, e.g. with y looped back to din.
- Reset asserted mid-operation returns everything to the reset values immediately, whatever the FSM state.

Test Plan:
- Generator sequence: WIDTH=4, TAPS=4'b1001, SEED=4'hF, gen_en=1 after reset → y = 1,1,1,1,0,1,0,1,1,0,0,1,0,0,0, repeating with period 15; gen_state back to 4'hF on step 15.
- Load and enable: load=1 with seed=4'h0 → gen_state=4'hF. load=1 with seed=4'h6 while gen_en=1 → gen_state=4'h6, then 4'h3. gen_en=0 for 5 cycles → gen_state unchanged.
- Lock: y looped to din with chk_en=gen_en=1, defaults WIDTH=7 and LOCK_CNT=14 → lock rises after exactly 7+14 enabled bits; err_cnt stays 0 for 1000 bits.
- Error injection: while locked, invert din on 3 isolated bits → three single-cycle err pulses, err_cnt=3, lock held. Then err_clr coincident with a 4th error → err_cnt=1.
- Loss of lock: while locked, drive din=0 constantly → err_cnt increments by 4 and lock falls on the 4th mismatch. It stays 0 indefinitely under all-zero input and relocks after the loopback is restored.
- Reset mid-operation: assert res asynchronously (between clock edges) while locked with err_cnt=5 → lock=0, err_cnt=0, err=0, gen_state=SEED immediately, without waiting for a clock edge.
